// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer: register modes,
// command opcodes and the sequencer FSM state type.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } usr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_t;

endpackage

// File: rtl/usr_sequencer.sv
// Command sequencer driving a universal shift register: turns LOAD/SHR/SHL/ROR
// commands into an exact number of register mode cycles, then pulses done.
module usr_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       mode,
    output logic             serial_in_left,
    output logic             serial_in_right,
    output logic [WIDTH-1:0] parallel_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_valid at any other time is ignored.

    usr_state_t       state, state_next;
    logic [CW-1:0]    count, count_next;
    usr_op_t          op_q, op_next;
    logic [1:0]       mode_next;
    logic             sil_next;
    logic             sir_fill_q, sir_fill_next;
    logic [WIDTH-1:0] par_next;
    logic             unused_q_bits;

    assign unused_q_bits = ^q_in[WIDTH-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            op_q           <= OP_LOAD;
            mode           <= MODE_HOLD;
            serial_in_left <= 1'b0;
            sir_fill_q     <= 1'b0;
            parallel_in    <= '0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            op_q           <= op_next;
            mode           <= mode_next;
            serial_in_left <= sil_next;
            sir_fill_q     <= sir_fill_next;
            parallel_in    <= par_next;
        end
    end

    // Register-facing outputs are set up on the acceptance edge so the first RUN
    // cycle already drives the active mode, and cleared on the edge leaving RUN.
    always_comb begin
        state_next    = state;
        count_next    = count;
        op_next       = op_q;
        mode_next     = mode;
        sil_next      = serial_in_left;
        sir_fill_next = sir_fill_q;
        par_next      = parallel_in;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next = usr_op_t'(cmd_op);
                    if (cmd_op == OP_LOAD) begin
                        state_next = ST_RUN;
                        count_next = CW'(1);
                        mode_next  = MODE_LOAD;
                        par_next   = cmd_data;
                    end else if (cmd_count == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_RUN;
                        count_next    = cmd_count;
                        mode_next     = (cmd_op == OP_SHL) ? MODE_SHL : MODE_SHR;
                        sil_next      = (cmd_op == OP_SHL) ? cmd_fill : 1'b0;
                        sir_fill_next = (cmd_op == OP_SHR) ? cmd_fill : 1'b0;
                    end
                end
            end
            ST_RUN: begin
                count_next = count - CW'(1);
                if (count == CW'(1)) begin
                    state_next    = ST_DONE;
                    mode_next     = MODE_HOLD;
                    sil_next      = 1'b0;
                    sir_fill_next = 1'b0;
                    par_next      = '0;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Rotation feeds the bit about to fall off q[0] straight back into the top.
    assign serial_in_right = sir_fill_q | ((state == ST_RUN && op_q == OP_ROR) ? q_in[0] : 1'b0);
    assign cmd_ready       = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer paired with a behavioural 4-bit universal shift register.
module tb_usr_sequencer;

    localparam int WIDTH = 4;
    localparam int CW    = 3;
    localparam int EW    = WIDTH + 18;

    logic             clk = 1'b0;
    logic             reset;
    logic             reg_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] q;
    logic [1:0]       mode;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [WIDTH-1:0] parallel_in;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    int checks   = 0;
    int failures = 0;

    // expected entry: {mode[1:0], done latency[7:0], active cycles[7:0], final q[3:0]}
    logic [EW-1:0] exp_q[$];
    bit            tracking = 0;
    int            lat_cnt  = 0;
    int            act_cnt  = 0;
    logic [1:0]    cur_op   = 2'b00;
    logic          cur_fill = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT and harness register ----------------
    usr_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_count      (cmd_count),
        .cmd_data       (cmd_data),
        .cmd_fill       (cmd_fill),
        .q_in           (q),
        .mode           (mode),
        .serial_in_left (serial_in_left),
        .serial_in_right(serial_in_right),
        .parallel_in    (parallel_in),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    always_ff @(posedge clk or posedge reg_rst) begin
        if (reg_rst) q <= '0;
        else begin
            case (mode)
                2'b01:   q <= {serial_in_right, q[WIDTH-1:1]};
                2'b10:   q <= {q[WIDTH-2:0], serial_in_left};
                2'b11:   q <= parallel_in;
                default: q <= q;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (tracking) begin
            e = exp_q[0];
            if (mode != 2'b00) begin
                act_cnt++;
                chk("active_mode", mode, e[EW-1 -: 2]);
                case (cur_op)
                    2'b00: begin
                        chk("load_par", parallel_in, e[WIDTH-1:0]);
                        chk("load_serial", {serial_in_left, serial_in_right}, 2'b00);
                    end
                    2'b01: chk("shr_serial", {serial_in_left, serial_in_right}, {1'b0, cur_fill});
                    2'b10: chk("shl_serial", {serial_in_left, serial_in_right}, {cur_fill, 1'b0});
                    default: chk("ror_serial", {serial_in_left, serial_in_right}, {1'b0, q[0]});
                endcase
            end else begin
                chk("idle_outputs", {serial_in_left, serial_in_right, parallel_in}, '0);
            end
            if (done) begin
                e = exp_q.pop_front();
                chk("final_q", q, e[WIDTH-1:0]);
                chk("done_latency", lat_cnt, e[WIDTH+15:WIDTH+8]);
                chk("active_cycles", act_cnt, e[WIDTH+7:WIDTH]);
                tracking = 0;
            end else begin
                chk("busy_running", busy, 1'b1);
                lat_cnt++;
            end
        end else if (done) begin
            chk("unexpected_done", done, 1'b0);
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] op, input int n, input logic [3:0] data,
                         input logic fill, input logic [3:0] exp_val,
                         input logic [1:0] emode, input int elat, input int eact,
                         input bit hold_busy);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_cmd", cmd_ready, 1'b1);
        exp_q.push_back({emode, 8'(elat), 8'(eact), exp_val});
        cur_op    = op;
        cur_fill  = fill;
        lat_cnt   = 0;
        act_cnt   = 0;
        cmd_op    = op;
        cmd_count = n[CW-1:0];
        cmd_data  = data;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        tracking = 1;
        if (hold_busy) begin
            cmd_op    = 2'b00;
            cmd_data  = 4'b0000;
            cmd_count = 3'd1;
            cmd_fill  = ~fill;
        end else begin
            cmd_valid = 1'b0;
        end
        guard = 0;
        while (tracking && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        cmd_valid = 1'b0;
        if (tracking) begin
            chk("done_timeout", 1'b0, 1'b1);
            tracking = 0;
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        reg_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mode", mode, 2'b00);
        chk("rst_serial", {serial_in_left, serial_in_right}, 2'b00);
        chk("rst_par", parallel_in, 4'b0000);
        chk("rst_q", q, 4'b0000);
        reset   = 1'b0;
        reg_rst = 1'b0;
        @(negedge clk);

        //     op     N  data     fill  exp q    mode   lat act hold
        issue(2'b00, 0, 4'b1011, 1'b0, 4'b1011, 2'b11, 1, 1, 0); // LOAD
        issue(2'b01, 1, 4'b0000, 1'b1, 4'b1101, 2'b01, 1, 1, 0); // SHR 1 fill 1
        issue(2'b10, 2, 4'b0000, 1'b0, 4'b0100, 2'b10, 2, 2, 0); // SHL 2 fill 0
        issue(2'b00, 0, 4'b1011, 1'b0, 4'b1011, 2'b11, 1, 1, 0); // LOAD
        issue(2'b11, 5, 4'b0000, 1'b0, 4'b1101, 2'b01, 5, 5, 0); // ROR 5 wraps
        issue(2'b01, 0, 4'b0000, 1'b1, 4'b1101, 2'b00, 0, 0, 0); // SHR 0: no shift
        issue(2'b10, 3, 4'b0000, 1'b1, 4'b1111, 2'b10, 3, 3, 1); // SHL 3, valid held while busy
        issue(2'b01, 7, 4'b0000, 1'b0, 4'b0000, 2'b01, 7, 7, 0); // SHR 7 > WIDTH flushes
        issue(2'b00, 0, 4'b0110, 1'b0, 4'b0110, 2'b11, 1, 1, 0); // LOAD
        issue(2'b10, 7, 4'b0000, 1'b1, 4'b1111, 2'b10, 7, 7, 0); // SHL 7 fill 1
        issue(2'b00, 0, 4'b1101, 1'b0, 4'b1101, 2'b11, 1, 1, 0); // LOAD

        // Abort SHR N=4 fill 0 in its third RUN cycle: 1101 -> 0110 -> 0011
        while (!cmd_ready) @(negedge clk);
        cmd_op    = 2'b01;
        cmd_count = 3'd4;
        cmd_fill  = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_mode", mode, 2'b01);
        chk("abort_pre_q", q, 4'b0011);
        reset = 1'b1;
        #1;
        chk("abort_mode", mode, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_outs", {serial_in_left, serial_in_right, parallel_in}, '0);
        @(negedge clk);
        chk("abort_q_held", q, 4'b0011);
        reset = 1'b0;
        issue(2'b00, 0, 4'b1001, 1'b0, 4'b1001, 2'b11, 1, 1, 0); // LOAD after abort

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
